if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction queue and pipeline register between the Fetch stage and the Decode stage.
- Captures each fetched instruction word and its PC, and buffers up to DEPTH entries in a circular FIFO.
- Presents the oldest entry to Decode with a valid/ready handshake.
- Discards all buffered, wrong-path instructions on a branch/jump flush.
- Inserts a NOP bubble whenever the queue is empty.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- CNT_W, 3, width of the count output; must equal clog2(DEPTH+1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  Fetch presents a valid instruction this cycle.
- in_inst  input  32  fetched instruction word.
- in_pc  input  32  address of in_inst.
- in_ready  output  1  queue can accept an entry this cycle.
- flush  input  1  branch/jump redirect; discards all contents.
- out_valid  output  1  head entry is valid.
- out_inst  output  32  head instruction; 32'h00000000 (NOP) when out_valid=0.
- out_pc  output  32  head PC; 0 when out_valid=0.
- out_pc4  output  32  out_pc + 4 (mod 2^32); 0 when out_valid=0.
- out_ready  input  1  Decode consumes the head this cycle.
- count  output  CNT_W  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (asynchronous, takes effect immediately when reset=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_inst=0, out_pc=0, out_pc4=0, in_ready=1.
  - Storage contents are don't-care after reset.
- Reset asserted mid-operation drops all entries with no partial-entry artefacts. First push is accepted on the first rising edge after reset deasserts.
- Push: push = in_valid & in_ready. On the edge, {in_inst, in_pc} is written at wr_ptr, and wr_ptr advances mod DEPTH.
- Pop: pop = out_valid & out_ready. On the edge, rd_ptr advances mod DEPTH.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0). out_inst and out_pc are read combinationally from the storage entry at rd_ptr, gated to 0 when empty.
- Latency:
  - An entry pushed on edge N is visible at the outputs after edge N, so it can be popped on edge N+1.
  - There is no same-cycle bypass from in_* to out_*.
- count update on a non-flush edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Flush has priority over push and pop. On an edge with flush=1:
  - count=0 and rd_ptr=wr_ptr.
  - Any simultaneous push is discarded and a simultaneous pop has no effect.
  - The queue is empty after the edge.
- Flush while empty is harmless. Flush held for multiple cycles keeps the queue empty.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap naturally. Ordering is strictly FIFO across the wrap.
- out_ready while empty is ignored, with no underflow. in_valid while full is ignored, with no overflow or overwrite.
- Fetch must hold its PC while in_ready=0. Fetch redirects its PC on the same edge that flush is asserted.
- Implementation style:
  - Storage is a DEPTH x 64-bit register array. Pointers and count are registers with asynchronous reset.
  - All outputs other than in_ready and out_valid are combinational reads of registered state.

Test Plan:
- Reset then idle: assert reset mid-cycle with no clk edge -> immediately count=0, out_valid=0, out_inst=0, in_ready=1.
- Single pass: push {inst=0x20080005, pc=0x00000000} on edge 1 with out_ready=1 -> after edge 1, out_valid=1, out_inst=0x20080005, out_pc4=0x00000004; after edge 2, count=0 and out_inst=0.
- Fill and backpressure: out_ready=0, push pc=0x0,0x4,0x8,0xC -> count=4, in_ready=0; in_valid with pc=0x10 is not stored; then out_ready=1 -> pops in order 0x0,0x4,0x8,0xC.
- Simultaneous push/pop with wrap: stream 10 instructions with in_valid=out_ready=1 continuously:
  - count stays at 1 after the first edge.
  - Output PCs appear in order 0x0..0x24, so pointers wrap twice.
  - No drops or duplicates.
- Flush priority: with count=3, assert flush, in_valid=1 and out_ready=1 on one edge -> count=0, out_valid=0; the flushed-cycle instruction never appears; the next push is the new head.
- Reset mid-operation: with count=2, pulse reset between edges -> outputs clear immediately; a push after reset is released appears as the sole entry with count=1.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-Decode instruction queue: circular FIFO of {inst, pc} entries with valid/ready on both
// sides, flush-to-empty on redirect, and NOP/zero outputs whenever the queue is empty.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc4,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [63:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [63:0]      head;

  // Handshake readiness depends only on registered occupancy.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Drop everything, including any entry offered this cycle.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= {in_inst, in_pc};
    end
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    out_inst = '0;
    out_pc   = '0;
    out_pc4  = '0;
    if (out_valid) begin
      out_inst = head[63:32];
      out_pc   = head[31:0];
      out_pc4  = head[31:0] + 32'd4;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the FIFO contents.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [31:0]      out_pc4;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;
  logic [63:0] mq[$];

  if_id_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_inst, e_pc, e_pc4;
    int n;
    n = mq.size();
    e_inst = '0;
    e_pc   = '0;
    e_pc4  = '0;
    if (n != 0) begin
      e_inst = mq[0][63:32];
      e_pc   = mq[0][31:0];
      e_pc4  = e_pc + 32'd4;
    end
    chk({tag, ".count"},     32'(count),     32'(n));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ".out_inst"},  out_inst,       e_inst);
    chk({tag, ".out_pc"},    out_pc,         e_pc);
    chk({tag, ".out_pc4"},   out_pc4,        e_pc4);
  endtask

  // Drive one cycle, update the model at the edge, then check just after it.
  task automatic cycle(input string tag, input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic rdy, input logic fl);
    bit do_push, do_pop;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      do_pop  = rdy && (mq.size() != 0);
      do_push = v && (mq.size() != DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({inst, pc});
    end
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #2;
    mq.delete();
    check_all(tag);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
    check_all("reset");
    reset = 1'b0;
    #2;
    check_all("idle");

    // Single pass
    cycle("single.push", 1'b1, 32'h2008_0005, 32'h0, 1'b1, 1'b0);
    chk("single.pc4", out_pc4, 32'h4);
    cycle("single.pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill and backpressure
    for (int i = 0; i < 4; i++) begin
      cycle("fill", 1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0);
    end
    chk("fill.in_ready_full", 32'(in_ready), 32'h0);
    cycle("fill.refused", 1'b1, $urandom, 32'h10, 1'b0, 1'b0);
    cycle("fill.full_pushpop", 1'b1, $urandom, 32'h10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Streaming with wrap
    for (int i = 0; i < 10; i++) begin
      cycle("stream", 1'b1, $urandom, 32'(i * 4), 1'b1, 1'b0);
      chk("stream.count1", 32'(count), 32'h1);
    end
    cycle("stream.tail", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush priority
    for (int i = 0; i < 3; i++) begin
      cycle("preflush", 1'b1, $urandom, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    end
    cycle("flush", 1'b1, 32'hdead_beef, 32'h200, 1'b1, 1'b1);
    cycle("flush.hold", 1'b1, 32'hdead_beef, 32'h204, 1'b0, 1'b1);
    cycle("postflush", 1'b1, 32'h1234_5678, 32'h300, 1'b0, 1'b0);
    chk("postflush.head", out_pc, 32'h300);

    // Reset mid-operation
    cycle("prereset", 1'b1, $urandom, 32'h304, 1'b0, 1'b0);
    pulse_reset("midreset");
    cycle("afterreset", 1'b1, 32'h0bad_cafe, 32'h400, 1'b0, 1'b0);
    chk("afterreset.count", 32'(count), 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), $urandom, $urandom & 32'hffff_fffc,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 99) == 0) pulse_reset("rand.reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
